// File: rtl/ttl_counter_n.sv
// ttl_counter_n: '161/'163-style synchronous counter with clear, load, enable, ripple carry
// Optional bidirectional counting is enabled by defining TTL_COUNTER_DOWN_EN (adds port up).
//
// Ports:
//   clk     - rising-edge clock; all state changes here
//   rst     - synchronous active-high reset, overrides everything
//   clr_n   - synchronous active-low clear (beats load and count)
//   load_n  - synchronous active-low parallel load of d
//   enp     - count enable P (does not gate rco)
//   ent     - count enable T (also gates rco, for cascading)
//   d       - parallel load data
//   up      - direction, 1 = up (TTL_COUNTER_DOWN_EN builds only)
//   q       - count, complemented when INVERT_OUT = 1
//   rco     - ripple carry out = ent & terminal count
module ttl_counter_n #(
   parameter int unsigned WIDTH      = 4,
   parameter bit          INVERT_OUT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_n,
   input  logic             load_n,
   input  logic             enp,
   input  logic             ent,
   input  logic [WIDTH-1:0] d,
`ifdef TTL_COUNTER_DOWN_EN
   input  logic             up,
`endif
   output logic [WIDTH-1:0] q,
   output logic             rco
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             dir_up;
   logic             term;

`ifdef TTL_COUNTER_DOWN_EN
   assign dir_up = up;
`else
   assign dir_up = 1'b1;
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (!clr_n) begin
         cnt_d = '0;
      end else if (!load_n) begin
         cnt_d = d;
      end else if (enp && ent) begin
         if (dir_up) cnt_d = cnt_q + WIDTH'(1);
         else        cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Terminal follows direction so cascaded stages borrow as well as carry;
   // enp is deliberately absent so a stalled chain still reports carry.
   always_comb begin
      term = dir_up ? (&cnt_q) : ~(|cnt_q);
      rco  = ent & term;
      q    = INVERT_OUT ? ~cnt_q : cnt_q;
   end

endmodule

// File: doc/ttl_counter_n.md
TTL_COUNTER_N -- requirements
Module: ttl_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4, setting counter bit width; legal range 2..32.
REQ-002 SHALL have parameter INVERT_OUT, default 0; when 1, q presents the bitwise complement of the internal count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port clr_n, input, 1, synchronous clear; active-low.
REQ-006 SHALL have port load_n, input, 1, synchronous parallel load; active-low.
REQ-007 SHALL have port enp, input, 1, count enable P.
REQ-008 SHALL have port ent, input, 1, count enable T; also gates rco.
REQ-009 SHALL have port d, input, WIDTH, parallel load data.
REQ-010 SHALL have port up, input, 1, count direction, 1 = up; present only with TTL_COUNTER_DOWN_EN.
REQ-011 SHALL have port q, output, WIDTH, count output, polarity per INVERT_OUT.
REQ-012 SHALL have port rco, output, 1, ripple carry out for cascading.

Function
REQ-013 SHALL hold an internal WIDTH-bit count register cnt, updated only on rising clk.
REQ-014 SHALL apply per-edge priority: rst, then clr_n=0, then load_n=0, then enp&ent count, else hold.
REQ-015 SHALL set cnt to 0 when clr_n=0, regardless of load_n, enp and ent.
REQ-016 SHALL set cnt to d when load_n=0 and clr_n=1, regardless of enp and ent; new value visible on q one cycle after the edge.
REQ-017 SHALL increment cnt by 1 modulo 2^WIDTH when counting up; all-ones wraps to 0 in one edge.
REQ-018 SHALL decrement cnt by 1 modulo 2^WIDTH when counting down; 0 wraps to all-ones.
REQ-019 SHALL hold cnt when enp=0 or ent=0 and no clear or load is active.
REQ-020 SHALL drive q = cnt when INVERT_OUT=0 and q = ~cnt when INVERT_OUT=1; this inversion SHALL NOT affect counting, load, or rco.
REQ-021 SHALL drive rco combinationally as ent AND terminal, with no dependence on enp.
REQ-022 SHALL define terminal as cnt all-ones when counting up and cnt zero when counting down.
REQ-023 SHALL ensure that cascading N instances, with rco feeding the next stage's ent and a shared enp, behaves as one N*WIDTH-bit synchronous counter with no extra latency.

Reset
REQ-024 SHALL set cnt to 0 on any rising clk with rst=1, overriding all other inputs.
REQ-025 SHALL, after reset, drive q to 0 when INVERT_OUT=0 or all-ones when INVERT_OUT=1, and drive rco to ent AND terminal.
REQ-026 SHALL abandon any count or load in progress when rst is asserted mid-sequence; counting resumes from 0 on the first edge with rst=0.

Configuration
REQ-027 SHALL use macro TTL_COUNTER_DOWN_EN to enable bidirectional counting.
REQ-028 SHALL, with TTL_COUNTER_DOWN_EN defined, provide port up and use it to select the direction for counting (REQ-017/018) and for terminal (REQ-022).
REQ-029 SHALL, without TTL_COUNTER_DOWN_EN, omit port up and count up only, with terminal meaning all-ones.

Verification
REQ-030 SHALL verify: WIDTH=4, rst=1 for 1 edge, then enp=ent=1 for 15 edges -> q=0,1,...,15; rco=1 only while q=15; the next edge gives q=0.
REQ-031 SHALL verify: at q=5, load_n=0, d=0xA, enp=ent=0 -> q=0xA after the edge; same edge with clr_n=0 also asserted -> q=0.
REQ-032 SHALL verify: q=0xF, ent=1, enp=0 -> rco=1 while q holds 0xF; ent=0 -> rco=0.
REQ-033 SHALL verify: two WIDTH=4 instances cascaded (rco into the next stage's ent), 256 count edges from 0 -> combined value steps 0x00..0xFF and then wraps to 0x00.
REQ-034 SHALL verify: INVERT_OUT=1, WIDTH=8, reset, then 3 count edges -> q=0xFF, 0xFE, 0xFD, 0xFC; rco=0 throughout.
REQ-035 SHALL verify, with TTL_COUNTER_DOWN_EN defined: up=0 from q=1 -> q=0 with rco=1, next edge q=0xF; rst asserted mid-count -> q=0 on that edge.
